// File: rtl/exec_pipe_if.sv
// exec_pipe_if: handshake bundle between an issuing stage and exec_pipe.
//   Request side : in_valid/in_ready, in_op, in_x, in_y, in_a, in_tag
//   Result side  : out_valid/out_ready, out_result, out_tag, out_err
//   Status       : busy (multiply in progress)
// master = issuer/consumer, slave = execution unit.
interface exec_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] in_a;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_op, in_x, in_y, in_a, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_a, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err, busy
    );
endinterface

// File: rtl/exec_pipe.sv
// exec_pipe: handshaked execution unit computing op(X, Y) + A over the
// 16-entry tenyr op encoding. Single-cycle ops write the one-entry output
// register at the accept edge; multiply iterates MUL_BITS per cycle for
// WIDTH/MUL_BITS cycles. Ops 4 and F are reserved: result = A, out_err = 1.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   pipe    : exec_pipe_if slave (request, result and busy signals)
module exec_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    exec_pipe_if.slave pipe
);
    localparam int N   = WIDTH / MUL_BITS;
    localparam int CW  = $clog2(N + 1);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] addend_q;
    logic [TAG_W-1:0] tag_pend_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;

    logic             in_ready;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] alu_d;
    logic             err_d;
    logic [WIDTH-1:0] digit_d;
    logic [WIDTH-1:0] acc_d;

    assign in_ready = (state_q == IDLE) & (~out_valid_q | pipe.out_ready);
    assign accept   = pipe.in_valid & in_ready;
    // Last iteration: counter is about to reach zero on this edge.
    assign mul_done = (state_q == MUL) && (cnt_q == CW'(1));

    assign pipe.in_ready   = in_ready;
    assign pipe.out_valid  = out_valid_q;
    assign pipe.out_result = out_result_q;
    assign pipe.out_tag    = out_tag_q;
    assign pipe.out_err    = out_err_q;
    assign pipe.busy       = (state_q == MUL);

    // Single-cycle op result before the addend. Multiply is handled by the
    // iterative path, so op 3 contributes nothing here.
    always_comb begin
        alu_d = '0;
        err_d = 1'b0;
        unique case (pipe.in_op)
            4'h0: alu_d = pipe.in_x | pipe.in_y;
            4'h1: alu_d = pipe.in_x & pipe.in_y;
            4'h2: alu_d = pipe.in_x + pipe.in_y;
            4'h5: alu_d = (pipe.in_y >= WIDTH'(WIDTH)) ? '0
                                                        : pipe.in_x << pipe.in_y[SHW-1:0];
            4'h6: alu_d = {WIDTH{$signed(pipe.in_x) < $signed(pipe.in_y)}};
            4'h7: alu_d = {WIDTH{pipe.in_x == pipe.in_y}};
            4'h8: alu_d = {WIDTH{$signed(pipe.in_x) > $signed(pipe.in_y)}};
            4'h9: alu_d = pipe.in_x & ~pipe.in_y;
            4'hA: alu_d = pipe.in_x ^ pipe.in_y;
            4'hB: alu_d = pipe.in_x - pipe.in_y;
            4'hC: alu_d = pipe.in_x ^ ~pipe.in_y;
            4'hD: alu_d = (pipe.in_y >= WIDTH'(WIDTH)) ? '0
                                                        : pipe.in_x >> pipe.in_y[SHW-1:0];
            4'hE: alu_d = {WIDTH{pipe.in_x != pipe.in_y}};
            4'h4, 4'hF: err_d = 1'b1;
            default: alu_d = '0;
        endcase
    end

    // One radix-2^MUL_BITS step; truncation to WIDTH keeps the low product
    // bits, which are the same for signed and unsigned operands.
    assign digit_d = WIDTH'(mplier_q[MUL_BITS-1:0]);
    assign acc_d   = acc_q + WIDTH'(mcand_q * digit_d);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            addend_q     <= '0;
            tag_pend_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            // Consume first; a result written below at this edge overrides.
            if (pipe.out_ready) out_valid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (pipe.in_op == 4'h3) begin
                            state_q    <= MUL;
                            cnt_q      <= CW'(N);
                            acc_q      <= '0;
                            mcand_q    <= pipe.in_x;
                            mplier_q   <= pipe.in_y;
                            addend_q   <= pipe.in_a;
                            tag_pend_q <= pipe.in_tag;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= alu_d + pipe.in_a;
                            out_tag_q    <= pipe.in_tag;
                            out_err_q    <= err_d;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_BITS;
                    mplier_q <= mplier_q >> MUL_BITS;
                    cnt_q    <= cnt_q - CW'(1);
                    if (mul_done) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= acc_d + addend_q;
                        out_tag_q    <= tag_pend_q;
                        out_err_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_pipe.sv
module tb_exec_pipe;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int MB = 4;
    localparam int N  = W / MB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    exec_pipe_if #(.WIDTH(W), .TAG_W(TW)) ifc();
    exec_pipe #(.WIDTH(W), .MUL_BITS(MB), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .pipe(ifc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  r;
        logic [TW-1:0] t;
        logic          e;
    } exp_t;

    // Reference: op semantics straight from the op table, 32-bit arithmetic.
    function automatic logic [W-1:0] ref_res(input logic [3:0] op,
                                             input logic [W-1:0] x, y, a);
        logic [W-1:0] r;
        case (op)
            4'h0: r = x | y;
            4'h1: r = x & y;
            4'h2: r = x + y;
            4'h3: r = x * y;
            4'h5: r = (y >= 32) ? 32'h0 : x << y;
            4'h6: r = ($signed(x) < $signed(y)) ? 32'hFFFF_FFFF : 32'h0;
            4'h7: r = (x == y) ? 32'hFFFF_FFFF : 32'h0;
            4'h8: r = ($signed(x) > $signed(y)) ? 32'hFFFF_FFFF : 32'h0;
            4'h9: r = x & ~y;
            4'hA: r = x ^ y;
            4'hB: r = x - y;
            4'hC: r = x ^ ~y;
            4'hD: r = (y >= 32) ? 32'h0 : x >> y;
            4'hE: r = (x != y) ? 32'hFFFF_FFFF : 32'h0;
            default: r = 32'h0;
        endcase
        return r + a;
    endfunction

    function automatic logic ref_err(input logic [3:0] op);
        return (op == 4'h4) || (op == 4'hF);
    endfunction

    // Stimulus only: offer one op, wait for acceptance and then a valid result.
    task automatic issue_and_wait(input logic [3:0] op, input logic [W-1:0] x, y, a,
                                  input logic [TW-1:0] tag,
                                  output logic [W-1:0] res, output logic [TW-1:0] rtag,
                                  output logic rerr, output bit ok);
        int n;
        ok = 0; res = '0; rtag = '0; rerr = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_op = op; ifc.in_x = x; ifc.in_y = y;
        ifc.in_a = a; ifc.in_tag = tag;
        n = 0;
        while (!ifc.in_ready && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        ifc.in_valid = 1'b0;
        n = 0;
        while (!ifc.out_valid && n < 40) begin @(negedge clk); n++; end
        if (ifc.out_valid) begin
            ok = 1; res = ifc.out_result; rtag = ifc.out_tag; rerr = ifc.out_err;
        end
    endtask

    task automatic test_reset;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b busy=%b out_err=%b want 0 0 0",
                     ifc.out_valid, ifc.busy, ifc.out_err);
        end
        checks++;
        if (ifc.out_result !== '0 || ifc.out_tag !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%h tag=%h want 0 0", ifc.out_result, ifc.out_tag);
        end
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
        end
    endtask

    // Back-to-back single-cycle ops with out_ready high: one result per cycle.
    task automatic test_basic;
        logic [3:0] ops [5];
        logic [W-1:0] exp;
        ops = '{4'h0, 4'h2, 4'hB, 4'hA, 4'hC};
        ifc.out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1'b1; ifc.in_op = ops[i]; ifc.in_x = 32'h0000_00F0;
            ifc.in_y = 32'h0000_000F; ifc.in_a = 32'h1; ifc.in_tag = TW'(i);
            #1;
            checks++;
            if (ifc.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready[%0d]: got %b want 1", i, ifc.in_ready);
            end
            @(posedge clk); @(negedge clk);
            exp = ref_res(ops[i], 32'h0000_00F0, 32'h0000_000F, 32'h1);
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_result !== exp || ifc.out_tag !== TW'(i)) begin
                errors++;
                $display("FAIL basic_op%h: valid=%b result=%h tag=%0d want 1 %h %0d",
                         ops[i], ifc.out_valid, ifc.out_result, ifc.out_tag, exp, i);
            end
        end
        ifc.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_compare;
        logic [3:0] ops [4];
        logic [W-1:0] as [4];
        logic [W-1:0] res, exp;
        logic [TW-1:0] rt;
        logic re;
        bit ok;
        ops = '{4'h6, 4'h8, 4'h7, 4'hE};
        as  = '{32'h0, 32'h0, 32'h0, 32'h5};
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(ops[i], 32'hFFFF_FFFF, 32'h1, as[i], 4'h3, res, rt, re, ok);
            exp = ref_res(ops[i], 32'hFFFF_FFFF, 32'h1, as[i]);
            checks++;
            if (!ok || res !== exp) begin
                errors++;
                $display("FAIL compare_op%h: ok=%0d result=%h want %h", ops[i], ok, res, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shift;
        logic [3:0] ops [3];
        logic [W-1:0] ys [3];
        logic [W-1:0] as [3];
        logic [W-1:0] res, exp;
        logic [TW-1:0] rt;
        logic re;
        bit ok;
        ops = '{4'h5, 4'hD, 4'h5};
        ys  = '{32'd1, 32'd31, 32'd32};
        as  = '{32'h0, 32'h0, 32'h7};
        for (int i = 0; i < 3; i++) begin
            issue_and_wait(ops[i], 32'h8000_0001, ys[i], as[i], 4'h5, res, rt, re, ok);
            exp = ref_res(ops[i], 32'h8000_0001, ys[i], as[i]);
            checks++;
            if (!ok || res !== exp) begin
                errors++;
                $display("FAIL shift_op%h_y%0d: ok=%0d result=%h want %h",
                         ops[i], ys[i], ok, res, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul;
        logic [W-1:0] res;
        logic [TW-1:0] rt;
        logic re;
        bit ok;
        int bad;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1; ifc.in_op = 4'h3; ifc.in_x = 32'h0001_0003;
        ifc.in_y = 32'h5; ifc.in_a = 32'h2; ifc.in_tag = 4'h9;
        @(posedge clk); @(negedge clk);
        ifc.in_valid = 1'b0;
        bad = 0;
        for (int i = 1; i <= N; i++) begin
            if (ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_busy_window: %0d of %0d cycles wrong, want busy=1 in_ready=0",
                     bad, N);
        end
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.busy !== 1'b0 ||
            ifc.out_result !== ref_res(4'h3, 32'h0001_0003, 32'h5, 32'h2) || ifc.out_tag !== 4'h9) begin
            errors++;
            $display("FAIL mul_result: valid=%b busy=%b result=%h tag=%h want 1 0 %h 9",
                     ifc.out_valid, ifc.busy, ifc.out_result, ifc.out_tag,
                     ref_res(4'h3, 32'h0001_0003, 32'h5, 32'h2));
        end
        @(negedge clk);
        issue_and_wait(4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'h2, res, rt, re, ok);
        checks++;
        if (!ok || res !== 32'h1 || re !== 1'b0) begin
            errors++;
            $display("FAIL mul_allones: ok=%0d result=%h err=%b want 00000001 0", ok, res, re);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] res, r1, r2;
        logic [TW-1:0] rt;
        logic re;
        bit ok;
        int bad;
        r1 = ref_res(4'h2, 32'h1000, 32'h0234, 32'h1);
        r2 = ref_res(4'hB, 32'h5000, 32'h0001, 32'h0);
        ifc.out_ready = 1'b0;
        issue_and_wait(4'h2, 32'h1000, 32'h0234, 32'h1, 4'h1, res, rt, re, ok);
        checks++;
        if (!ok || res !== r1) begin
            errors++;
            $display("FAIL bp_r1: ok=%0d result=%h want %h", ok, res, r1);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 ||
                ifc.out_result !== r1 || ifc.out_tag !== 4'h1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 5 cycles changed, want in_ready=0 result %h held",
                     bad, r1);
        end
        ifc.in_valid = 1'b1; ifc.in_op = 4'hB; ifc.in_x = 32'h5000; ifc.in_y = 32'h1;
        ifc.in_a = 32'h0; ifc.in_tag = 4'h2; ifc.out_ready = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", ifc.in_ready);
        end
        @(posedge clk); @(negedge clk);
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_result !== r2 || ifc.out_tag !== 4'h2) begin
            errors++;
            $display("FAIL bp_replace: valid=%b result=%h tag=%h want 1 %h 2",
                     ifc.out_valid, ifc.out_result, ifc.out_tag, r2);
        end
        @(negedge clk);
    endtask

    task automatic test_reserved;
        logic [W-1:0] res;
        logic [TW-1:0] rt;
        logic re;
        bit ok;
        issue_and_wait(4'h4, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234, 4'h7, res, rt, re, ok);
        checks++;
        if (!ok || res !== 32'h1234 || re !== 1'b1 || rt !== 4'h7) begin
            errors++;
            $display("FAIL reserved_op4: ok=%0d result=%h err=%b tag=%h want 00001234 1 7",
                     ok, res, re, rt);
        end
        @(negedge clk);
        issue_and_wait(4'h0, 32'h1, 32'h2, 32'h0, 4'h8, res, rt, re, ok);
        checks++;
        if (!ok || res !== 32'h3 || re !== 1'b0) begin
            errors++;
            $display("FAIL reserved_clear: ok=%0d result=%h err=%b want 00000003 0", ok, res, re);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        int stale;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1; ifc.in_op = 4'h3; ifc.in_x = 32'h1234_5678;
        ifc.in_y = 32'h9; ifc.in_a = 32'h0; ifc.in_tag = 4'hC;
        @(posedge clk); @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL midmul_reset: out_valid=%b busy=%b want 0 0", ifc.out_valid, ifc.busy);
        end
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midmul_stale: out_valid seen %0d cycles want 0", stale);
        end
    endtask

    // Random traffic with random back-pressure against a scoreboard.
    task automatic test_random;
        exp_t sb[$];
        exp_t e;
        bit acc, fire;
        logic [TW-1:0] tag;
        int n;
        tag = '0;
        acc = 1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (acc || !ifc.in_valid) begin
                ifc.in_valid = ($urandom_range(0, 3) != 0);
                ifc.in_op = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'($urandom_range(0, 15));
                ifc.in_x = $urandom;
                ifc.in_y = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
                ifc.in_a = $urandom;
                ifc.in_tag = tag;
            end
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fire = ifc.out_valid && ifc.out_ready;
            acc  = ifc.in_valid && ifc.in_ready;
            if (ifc.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: result=%h tag=%h with nothing outstanding",
                             ifc.out_result, ifc.out_tag);
                end else if (ifc.out_result !== sb[0].r || ifc.out_tag !== sb[0].t ||
                             ifc.out_err !== sb[0].e) begin
                    errors++;
                    $display("FAIL rand_result: got %h/%h/%b want %h/%h/%b",
                             ifc.out_result, ifc.out_tag, ifc.out_err, sb[0].r, sb[0].t, sb[0].e);
                end
                if (fire && sb.size() != 0) void'(sb.pop_front());
            end
            if (acc) begin
                e.r = ref_res(ifc.in_op, ifc.in_x, ifc.in_y, ifc.in_a);
                e.t = ifc.in_tag;
                e.e = ref_err(ifc.in_op);
                sb.push_back(e);
                tag = tag + 1'b1;
            end
            @(posedge clk); @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 4 * N) begin
            #1;
            if (ifc.out_valid === 1'b1) begin
                checks++;
                if (ifc.out_result !== sb[0].r || ifc.out_tag !== sb[0].t) begin
                    errors++;
                    $display("FAIL rand_drain: got %h/%h want %h/%h",
                             ifc.out_result, ifc.out_tag, sb[0].r, sb[0].t);
                end
                void'(sb.pop_front());
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand_lost: %0d results never appeared", sb.size());
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_op = '0; ifc.in_x = '0; ifc.in_y = '0;
        ifc.in_a = '0; ifc.in_tag = '0; ifc.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_compare();
        test_shift();
        test_mul();
        test_backpressure();
        test_reserved();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
